// File: rtl/ex_cnt_pkg.sv
// ex_cnt_pkg: types and default constants shared by the
// free-running counter and its sequence checker.
package ex_cnt_pkg;

  localparam int DEF_CNT_W   = 10;
  localparam int DEF_CNT_MAX = 1023;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/ex_cnt_chk_sat.sv
// ex_cnt_chk_sat: saturating up-counter with sync clear.
// A clear coinciding with an increment leaves the count at one.
module ex_cnt_chk_sat
  import ex_cnt_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = W'(inc_i);
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_cnt_chk.sv
// ex_cnt_chk: sequence checker for the free-running counter.
// Hunts, locks after LOCK_N matches, flags breaks and wraps.
module ex_cnt_chk
  import ex_cnt_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CNT_MAX = DEF_CNT_MAX,
  parameter int LOCK_N  = 4,
  parameter int ERR_W   = 16
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(CNT_MAX);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] exp_q, exp_d, nxt;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             in_rng, hit;
  logic             err_d, wrap_d;
  logic             err_q, wrap_q;

  // widened compare stays meaningful when CNT_MAX is all ones
  assign in_rng  = {1'b0, cnt_in} <= {1'b0, MAX_V};
  assign nxt     = (cnt_in == MAX_V) ? '0 : cnt_in + 1'b1;
  assign hit     = in_rng && (cnt_in == exp_q);
  assign run_inc = run_q + 1'b1;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (cnt_vld) begin
      unique case (state_q)
        HUNT: begin
          if (in_rng) begin
            exp_d   = nxt;
            run_d   = '0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          exp_d = nxt;
          if (hit) begin
            run_d = run_inc;
            if (run_inc == LOCK_V) state_d = LOCKED;
          end else begin
            run_d   = '0;
            state_d = in_rng ? CHECK : HUNT;
          end
        end
        LOCKED: begin
          exp_d = nxt;
          if (hit) begin
            wrap_d = (cnt_in == MAX_V);
          end else begin
            err_d   = 1'b1;
            run_d   = '0;
            state_d = in_rng ? CHECK : HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err_pulse  = err_q;
  assign wrap_pulse = wrap_q;

  ex_cnt_chk_sat #(
    .W (ERR_W)
  ) u_err (
    .clk_i (sclk),
    .rst_i (rst),
    .clr_i (clr_err),
    .inc_i (err_d),
    .cnt_o (err_cnt)
  );

endmodule

// File: doc/ex_cnt_chk.md
# ex_cnt_chk

Sequence checker for the 10-bit free-running counter output. It samples the count bus each valid cycle and verifies that every value is the previous value plus one, wrapping from CNT_MAX to 0. It reports lock status, error pulses, a saturating error count and a wrap strobe. It sits downstream of the counter and is used both as an on-chip health monitor and as a self-checking element in counter simulations.

## Interface
- CNT_W, 10, width of the checked count bus
- CNT_MAX, 1023, terminal count; the next expected value after CNT_MAX is 0; must be ≤ 2^CNT_W−1
- LOCK_N, 4, consecutive matching samples required to declare lock (≥1)
- ERR_W, 16, width of the error counter

- sclk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cnt_in  in  CNT_W  count value under check
- cnt_vld  in  1  cnt_in is valid this cycle; samples with cnt_vld=0 are ignored
- clr_err  in  1  synchronous clear of err_cnt
- locked  out  1  high while in LOCKED state
- err_pulse  out  1  one-cycle strobe per sequence error detected while locked
- err_cnt  out  ERR_W  saturating count of err_pulse events
- wrap_pulse  out  1  one-cycle strobe when a locked, matching sample equals CNT_MAX

## Operation
- Internal registers: state, exp (CNT_W, next expected value), run (counter 0..LOCK_N).
- next(v) = (v == CNT_MAX) ? 0 : v+1. A sample with value > CNT_MAX is out of range and never matches.
- States and transitions (evaluated only on cycles where cnt_vld=1):
  - HUNT: in-range sample → exp=next(sample), run=0, go to CHECK. Out-of-range sample → stay in HUNT.
  - CHECK: sample==exp → exp=next(sample), run+1; when run+1==LOCK_N go to LOCKED. Mismatch → resync (exp=next(sample), run=0), stay in CHECK; an out-of-range mismatch returns to HUNT. No errors are counted in this state.
  - LOCKED: sample==exp → exp=next(sample); wrap_pulse if sample==CNT_MAX. Mismatch → err_pulse, err_cnt+1, resync as in CHECK, go to CHECK (out-of-range → HUNT).
- err_cnt saturates at 2^ERR_W−1; err_pulse still fires at saturation.
- clr_err: err_cnt→0. If clr_err and an error occur in the same cycle, err_cnt→1.
- cnt_vld=0 freezes state, exp and run; strobes stay low.

## Timing
- All outputs are registered. Response appears on the sclk edge following the sampling edge (1-cycle latency).
- Reset (asserted at any time, including mid-sequence): state=HUNT, exp=0, run=0, locked=0, err_pulse=0, err_cnt=0, wrap_pulse=0, all immediately and asynchronously. The first valid sample after rst deasserts is treated as a HUNT capture.
- Lock latency: the first in-range valid sample plus LOCK_N matching valid samples; locked rises one cycle after the LOCK_N-th match.
- locked falls in the same cycle that err_pulse rises.
- err_pulse and wrap_pulse are never high in the same cycle.

## Structure
- The shared package ex_cnt_pkg holds the state enum (HUNT, CHECK, LOCKED) and the default CNT_W/CNT_MAX constants shared with the counter.
- One sub-module is natural: ex_cnt_chk_sat, a parameterised saturating up-counter with synchronous clear and increment, used for err_cnt.
- Everything else lives in a single always block for the FSM, plus output registers.

## Test plan
- Reset, then a continuous valid ramp starting at 0 with defaults → locked=1 after sample 4 is registered, err_cnt=0, wrap_pulse once per 1024 valid cycles at cnt_in=1023.
- Locked ramp, inject a single skip (…,100,102,103,…) → one err_pulse, err_cnt=1, locked drops, relocks after 102 plus 4 matches.
- cnt_vld toggled 50% during a locked ramp, with the count held on idle cycles → no errors, locked stays high; with garbage on idle cycles → still no errors.
- CNT_MAX=9, ramp 0..9,0.. → wrap_pulse at each 9; inject value 12 → err_pulse, state HUNT, locked=0.
- Force ERR_W=2, inject 5 errors → err_cnt sticks at 3, 5 err_pulses; clr_err on the same cycle as the 6th error → err_cnt=1.
- Assert rst mid-lock → all outputs 0 immediately; relock timing after release matches the first scenario.
